// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: the skid-stage state encoding and the
// control-field widths carried between the EX/MEM/WB stages.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int MEM_CTRL_W = 2;
    localparam int WB_CTRL_W  = 2;
    localparam int EX_CTRL_W  = MEM_CTRL_W + WB_CTRL_W;

    // The state encoding doubles as the held-entry count.
    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
    endfunction

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// One pipeline entry: {valid, ctrl, data} register with load and clear.
// Clear drops valid and ctrl but leaves the payload bits in place.
module pipe_entry
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [WIDTH-1:0]  d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [WIDTH-1:0]  q_data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = d_ctrl;
            data_d  = d_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign q_valid = valid_q;
    assign q_ctrl  = ctrl_q;
    assign q_data  = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: head entry drives the outputs, an optional skid
// entry absorbs one extra item so in_ready can come from a flop.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occupancy
);

    // Handshake: an item moves only when valid & ready are both high on a
    // rising edge with stall and flush low; flush beats everything.

    skid_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              push, pop;

    logic              head_load, head_clear;
    logic [CTRL_W-1:0] head_ctrl_d;
    logic [WIDTH-1:0]  head_data_d;
    logic              head_valid;
    logic [CTRL_W-1:0] head_ctrl;
    logic [WIDTH-1:0]  head_data;

    logic              skid_load, skid_clear;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [WIDTH-1:0]  skid_data;

    assign push = in_valid & in_ready_q & ~stall & ~flush;
    assign pop  = head_valid & out_ready & ~stall & ~flush;

    always_comb begin
        state_d     = state_q;
        head_load   = 1'b0;
        head_clear  = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        head_ctrl_d = in_ctrl;
        head_data_d = in_data;
        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push && SKID != 0) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (pop) begin
                        head_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_load   = 1'b1;
                        head_ctrl_d = skid_ctrl;
                        head_data_d = skid_data;
                        skid_clear  = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            endcase
        end
        // Ready is a function of the next state only, never of out_ready.
        if (SKID != 0) in_ready_d = (state_d != ST_TWO);
        else           in_ready_d = (state_d == ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_entry #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_head (
        .clk     (clk),
        .rst     (rst),
        .load    (head_load),
        .clear   (head_clear),
        .d_ctrl  (head_ctrl_d),
        .d_data  (head_data_d),
        .q_valid (head_valid),
        .q_ctrl  (head_ctrl),
        .q_data  (head_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .d_ctrl  (in_ctrl),
                .d_data  (in_data),
                .q_valid (skid_valid),
                .q_ctrl  (skid_ctrl),
                .q_data  (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid_ctl;
            assign unused_skid_ctl = skid_load | skid_clear;
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

    // Occupancy is tracked by the state; the skid valid bit is redundant.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

    assign in_ready  = in_ready_q;
    assign out_valid = head_valid;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a SKID=1 and a SKID=0 instance share stimulus and
// are each compared against a queue model of capacity 2 or 1.
module tb_pipe_skid_reg;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int E  = W + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, stall, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [W-1:0]  in_data;

    logic          in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl1;
    logic [W-1:0]  out_data1;
    logic [1:0]    occ1;

    logic          in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl0;
    logic [W-1:0]  out_data0;
    logic [1:0]    occ0;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [E-1:0]  exp_q[$];
    logic [E-1:0]  exp0_q[$];
    bit            init_done = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(W), .CTRL_W(CW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_skid_reg #(.WIDTH(W), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string pfx, input logic ov, input logic rdy,
                             input logic [1:0] occ, input logic [CW-1:0] oc,
                             input logic [W-1:0] od, input int size,
                             input logic [E-1:0] head, input int cap);
        check({pfx, "_out_valid"}, 32'(ov), 32'(size != 0));
        check({pfx, "_occupancy"}, 32'(occ), 32'(size));
        check({pfx, "_in_ready"}, 32'(rdy), 32'(init_done && size < cap));
        if (size != 0) begin
            check({pfx, "_out_ctrl"}, 32'(oc), 32'(head[E-1:W]));
            check({pfx, "_out_data"}, 32'(od), 32'(head[W-1:0]));
        end else begin
            check({pfx, "_out_ctrl_idle"}, 32'(oc), 32'd0);
        end
    endtask

    task automatic check_all();
        check_dut("skid1", out_valid1, in_ready1, occ1, out_ctrl1, out_data1,
                  exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : '0, 2);
        check_dut("skid0", out_valid0, in_ready0, occ0, out_ctrl0, out_data0,
                  exp0_q.size(), (exp0_q.size() != 0) ? exp0_q[0] : '0, 1);
    endtask

    // Called at a falling edge: drive inputs, advance the model, check after the edge.
    task automatic cycle(input bit v, input bit ordy, input bit st, input bit fl,
                         input logic [CW-1:0] c, input logic [W-1:0] d);
        bit push1, pop1, push0, pop0;
        in_valid  = v;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        in_ctrl   = c;
        in_data   = d;
        push1 = v && init_done && exp_q.size() < 2 && !st && !fl;
        pop1  = exp_q.size() > 0 && ordy && !st && !fl;
        push0 = v && init_done && exp0_q.size() < 1 && !st && !fl;
        pop0  = exp0_q.size() > 0 && ordy && !st && !fl;
        if (fl) begin
            exp_q.delete();
            exp0_q.delete();
        end else begin
            if (pop1)  void'(exp_q.pop_front());
            if (push1) exp_q.push_back({c, d});
            if (pop0)  void'(exp0_q.pop_front());
            if (push0) exp0_q.push_back({c, d});
        end
        if (rst) init_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, ordy, 1'b0, 1'b0, CW'($urandom), W'($urandom));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #1;
        check("reset_out_data", 32'(out_data1), 32'd0);
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_all();
        idle(1'b0);
        check("ready_after_release", 32'(in_ready1), 32'd1);

        // back-to-back streaming
        cycle(1, 1, 0, 0, 4'h1, 16'h0011);
        check("stream_first", 32'(out_data1), 32'h11);
        cycle(1, 1, 0, 0, 4'h2, 16'h0022);
        cycle(1, 1, 0, 0, 4'h3, 16'h0033);
        idle(1'b1);
        idle(1'b1);

        // backpressure fill, refused third, re-offer
        cycle(1, 0, 0, 0, 4'h5, 16'h00A0);
        cycle(1, 0, 0, 0, 4'h6, 16'h00A1);
        check("fill_occ", 32'(occ1), 32'd2);
        cycle(1, 0, 0, 0, 4'h7, 16'h00A2);
        cycle(1, 1, 0, 0, 4'h7, 16'h00A2);
        cycle(1, 1, 0, 0, 4'h7, 16'h00A2);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // stall freeze at occupancy 2
        cycle(1, 0, 0, 0, 4'h8, 16'h00B0);
        cycle(1, 0, 0, 0, 4'h9, 16'h00B1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 4'hA, 16'h00BF);
        check("stall_head", 32'(out_data1), 32'hB0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // flush beats stall, push and pop
        cycle(1, 0, 0, 0, 4'hB, 16'h00C0);
        cycle(1, 0, 0, 0, 4'hC, 16'h00C1);
        cycle(1, 1, 1, 1, 4'hD, 16'h00C2);
        check("flush_occ", 32'(occ1), 32'd0);
        idle(1'b1);

        // asynchronous reset between edges
        cycle(1, 0, 0, 0, 4'hE, 16'h00D0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        exp0_q.delete();
        init_done = 1'b0;
        check("async_rst_valid", 32'(out_valid1), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        check_all();
        idle(1'b1);
        check("ready_after_rst", 32'(in_ready1), 32'd1);

        // continuous stream: SKID=0 instance alternates ready
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, CW'(i), W'(16'h0E00 + i));
        idle(1'b1);
        idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                  CW'($urandom), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: payload data width in bits, minimum 1.
- REQ-002 SHALL have parameter CTRL_W, default 4: control-field width in bits, minimum 1; cleared on flush and reset.
- REQ-003 SHALL have parameter SKID, default 1.
  - 1: two-entry elastic stage.
  - 0: single-entry stage.
- REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
- REQ-007 SHALL have port stall, input, 1 bit: hazard-unit freeze; blocks both transfers.
- REQ-008 SHALL have port in_valid, input, 1 bit: upstream entry present.
- REQ-009 SHALL have port in_ready, output, 1 bit: stage can accept.
- REQ-010 SHALL have port in_ctrl, input, CTRL_W bits: upstream control field.
- REQ-011 SHALL have port in_data, input, WIDTH bits: upstream payload.
- REQ-012 SHALL have port out_valid, output, 1 bit: head entry present.
- REQ-013 SHALL have port out_ready, input, 1 bit: downstream can accept.
- REQ-014 SHALL have port out_ctrl, output, CTRL_W bits: head control field; 0 whenever out_valid=0.
- REQ-015 SHALL have port out_data, output, WIDTH bits: head payload.
- REQ-016 SHALL have port occupancy, output, 2 bits: held entries, 0..2.

Function
- REQ-017 SHALL define the handshake terms as follows.
  - Push: in_valid & in_ready & ~stall & ~flush.
  - Pop: out_valid & out_ready & ~stall & ~flush.
- REQ-018 SHALL implement states EMPTY, ONE, TWO (TWO only when SKID=1); occupancy encodes the state as 0/1/2.
- REQ-019 SHALL take these transitions.
  - EMPTY: push -> ONE.
  - ONE: push without pop -> TWO; push with pop -> ONE with new head; pop alone -> EMPTY.
  - TWO: pop -> ONE, skid entry promoted to head.
  - All other cases hold state.
- REQ-020 SHALL drive in_ready from a register only, never combinationally from out_ready.
  - SKID=1: in_ready=1 in EMPTY and ONE, 0 in TWO.
  - SKID=0: in_ready=1 in EMPTY only.
- REQ-021 SHALL present a pushed entry on out_valid/out_ctrl/out_data the cycle after the push (latency 1); sustained throughput is 1 entry/cycle when SKID=1.
- REQ-022 SHALL preserve FIFO order; no entry is duplicated or dropped except by flush.
- REQ-023 SHALL, with stall=1, hold state, occupancy, outputs and in_ready unchanged.
- REQ-024 SHALL, with flush=1, move to EMPTY next cycle.
  - Both ctrl fields clear to 0; data registers may retain stale values.
  - Flush overrides stall and any same-cycle push or pop.
- REQ-025 SHALL ignore in_ctrl/in_data when no push occurs.
- REQ-026 SHALL neither push in TWO nor pop in EMPTY; both are gated by the handshake terms.

Reset
- REQ-027 SHALL, on rst low, set asynchronously the following.
  - State EMPTY, occupancy=0.
  - out_valid=0, out_ctrl=0, out_data=0.
  - in_ready=0.
- REQ-028 SHALL assert in_ready=1 on the first rising clk edge after rst deasserts.
- REQ-029 SHALL, if reset asserts mid-operation, discard all entries with no partial pop.

Structure
- REQ-030 SHALL take the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) from the shared pipeline package, alongside the EX/MEM/WB control-field widths (MEM_CTRL_W=2, WB_CTRL_W=2).
- REQ-031 SHALL build the two entries from one sub-module, pipe_entry: a register holding {valid, ctrl, data} with load and clear; two instances when SKID=1, one when SKID=0.
- REQ-032 SHALL contain no latches and no combinational path from out_ready to in_ready.

Verification
- REQ-033 Back-to-back streaming: SKID=1, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> each appears one cycle later in order, occupancy stays 1, in_ready stays 1.
- REQ-034 Backpressure fill: out_ready=0, push 0xA0 then 0xA1 -> occupancy 2, in_ready=0, third push 0xA2 refused. Raise out_ready -> 0xA0, 0xA1, then 0xA2 (after re-offer), no loss.
- REQ-035 Stall freeze: occupancy 2, stall=1 for 3 cycles with in_valid=out_ready=1 -> outputs, occupancy and in_ready constant. Release -> pops resume with the same head.
- REQ-036 Flush priority: occupancy 2, flush=1 together with stall=1, in_valid=1, out_ready=1 -> next cycle occupancy 0, out_valid=0, out_ctrl=0; the offered entry is not stored.
- REQ-037 Async reset mid-stream: rst low between clock edges while occupancy=1 -> out_valid=0 and occupancy=0 immediately. First edge after release -> in_ready=1.
- REQ-038 SKID=0 mode: out_ready=1, continuous in_valid -> in_ready alternates 1/0, throughput one entry per two cycles, order preserved.
